// File: rtl/ms_sync_arbiter_pkg.sv
// Shared types and constants for the ms_sync_arbiter slice: FSM state
// encoding, counter widths and the round-robin index helper.
package ms_sync_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP
    } ms_arb_state_t;

    localparam int GAP_W = 4;
    localparam int CNT_W = 16;

    // Index visited at a given step of a search that starts just after `last`.
    function automatic int rr_index(input int last, input int step, input int n);
        return (last + step) % n;
    endfunction

endpackage

// File: rtl/ms_sync_arbiter_rr_picker.sv
// Combinational round-robin picker: starts searching one place after the
// previous winner, wraps upward, and returns the first active requester.
module rr_picker
    import ms_sync_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   winner
);

    logic [IDX_W-1:0] cand;

    // NOTE: every variable gets a default before the loop so no path infers a latch.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'(rr_index(int'(last), i, NUM_REQ));
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/ms_sync_arbiter.sv
// Round-robin arbiter sharing one slave input channel among NUM_REQ masters.
// Optional grant counter output enabled by `define MS_SYNC_ARBITER_GRANT_CNT_EN.
module ms_sync_arbiter
    import ms_sync_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic [DATA_W-1:0]           s_in,
    output logic                        s_in_sync,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
`ifdef MS_SYNC_ARBITER_GRANT_CNT_EN
    output logic [CNT_W-1:0]            grant_cnt,
`endif
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    ms_arb_state_t       state, state_d;
    logic [GAP_W-1:0]    gap_cnt, gap_cnt_d;
    logic [DATA_W-1:0]   s_in_d;
    logic                s_in_sync_d;
    logic [NUM_REQ-1:0]  ack_d;
    logic [IDX_W-1:0]    grant_id_d;
    logic                busy_d;
    logic                found;
    logic [IDX_W-1:0]    winner;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req),
        .last   (grant_id),
        .found  (found),
        .winner (winner)
    );

    always_comb begin
        state_d     = state;
        gap_cnt_d   = gap_cnt;
        s_in_d      = s_in;
        s_in_sync_d = 1'b0;
        ack_d       = '0;
        grant_id_d  = grant_id;
        case (state)
            ST_IDLE: begin
                if (found) begin
                    s_in_d      = req_data[winner*DATA_W +: DATA_W];
                    grant_id_d  = winner;
                    s_in_sync_d = 1'b1;
                    ack_d       = NUM_REQ'(1) << winner;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // NOTE: non-blocking assignments so every register updates from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            gap_cnt   <= '0;
            s_in      <= '0;
            s_in_sync <= 1'b0;
            ack       <= '0;
            grant_id  <= IDX_W'(NUM_REQ - 1);
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            gap_cnt   <= gap_cnt_d;
            s_in      <= s_in_d;
            s_in_sync <= s_in_sync_d;
            ack       <= ack_d;
            grant_id  <= grant_id_d;
            busy      <= busy_d;
        end
    end

`ifdef MS_SYNC_ARBITER_GRANT_CNT_EN
    // Saturating count of completed issue cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (state == ST_ISSUE && grant_cnt != {CNT_W{1'b1}}) begin
            grant_cnt <= grant_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ms_sync_arbiter.sv
// Scoreboard bench for ms_sync_arbiter: a cycle-count reference model queues
// expected issues; a negedge monitor pops and compares every strobe.
module tb_ms_sync_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int GAP     = 1;
    localparam int IDX_W   = $clog2(NUM_REQ);

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         s_in;
    logic                      s_in_sync;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;
`ifdef MS_SYNC_ARBITER_GRANT_CNT_EN
    logic [15:0]               grant_cnt;
`endif

    ms_sync_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_W     (DATA_W),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .s_in      (s_in),
        .s_in_sync (s_in_sync),
        .grant_id  (grant_id),
`ifdef MS_SYNC_ARBITER_GRANT_CNT_EN
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                cyc;
        int                id;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              q[$];
    int                cyc = 0;
    int                next_free = 0;
    int                busy_until = -1;
    int                last = NUM_REQ - 1;
    int                last_issue = -10;
    logic [DATA_W-1:0] exp_s_in = '0;
    int                exp_gid = NUM_REQ - 1;
    logic [15:0]       cnt_exp = '0;
    int                n_cmp = 0;
    int                n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: an issue may start at any edge at least 2+GAP edges after
    // the previous one; the winner is the first active requester after the last.
    initial forever begin
        int  id;
        bit  hit;
        @(posedge clk or posedge rst);
        if (rst) begin
            q.delete();
            cyc        = 0;
            next_free  = 0;
            busy_until = -1;
            last       = NUM_REQ - 1;
            last_issue = -10;
            exp_s_in   = '0;
            exp_gid    = NUM_REQ - 1;
            cnt_exp    = '0;
        end else begin
            cyc++;
            if (cyc == last_issue + 1 && cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 1'b1;
            if (cyc >= next_free && req != '0) begin
                hit = 1'b0;
                for (int j = 1; j <= NUM_REQ; j++) begin
                    id = (last + j) % NUM_REQ;
                    if (!hit && req[id]) begin
                        hit = 1'b1;
                        q.push_back('{cyc: cyc, id: id, data: req_data[id*DATA_W +: DATA_W]});
                        exp_s_in   = req_data[id*DATA_W +: DATA_W];
                        exp_gid    = id;
                        last       = id;
                        last_issue = cyc;
                        next_free  = cyc + 2 + GAP;
                        busy_until = cyc + GAP;
                    end
                end
            end
        end
    end

    // Monitor: compares every cycle's outputs against the model's expectations.
    initial forever begin
        exp_t               e;
        logic [NUM_REQ-1:0] exp_ack;
        @(negedge clk);
        if (!rst) begin
            if (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("missing_strobe", 64'(0), 64'(1));
            end
            if (s_in_sync) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", 64'(1), 64'(0));
                end else begin
                    e = q.pop_front();
                    exp_ack = NUM_REQ'(1) << e.id;
                    check("strobe_cycle", 64'(cyc), 64'(e.cyc));
                    check("strobe_grant_id", 64'(grant_id), 64'(e.id));
                    check("strobe_data", 64'(s_in), 64'(e.data));
                    check("strobe_ack", 64'(ack), 64'(exp_ack));
                end
            end else begin
                check("ack_idle", 64'(ack), 64'(0));
            end
            check("busy", 64'(busy), 64'(cyc <= busy_until));
            check("s_in_hold", 64'(s_in), 64'(exp_s_in));
            check("grant_id_hold", 64'(grant_id), 64'(exp_gid));
`ifdef MS_SYNC_ARBITER_GRANT_CNT_EN
            check("grant_cnt", 64'(grant_cnt), 64'(cnt_exp));
`endif
        end
    end

    task automatic set_data(input int i, input logic [DATA_W-1:0] v);
        req_data[i*DATA_W +: DATA_W] = v;
    endtask

    // Advance n cycles, each requester dropping its request once acked.
    task automatic tick_auto(input int n);
        repeat (n) begin
            @(negedge clk);
            req = req & ~ack;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state held with no requests.
        repeat (5) @(negedge clk);
        check("rst_s_in", 64'(s_in), 64'(0));
        check("rst_sync", 64'(s_in_sync), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_grant_id", 64'(grant_id), 64'(3));

        // Single request from requester 2.
        set_data(2, 32'h0000_00AA);
        req = 4'b0100;
        @(negedge clk);
        check("single_sync", 64'(s_in_sync), 64'(1));
        check("single_ack", 64'(ack), 64'(4'b0100));
        req = req & ~ack;
        tick_auto(5);

        // All four requesting continuously from a fresh pointer.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_data(i, DATA_W'(i + 10));
        req = 4'b1111;
        repeat (12) @(negedge clk);
        req = '0;
        check("rr_last_grant", 64'(grant_id), 64'(3));

        // Wrap-around: pointer at 3, requesters 0 and 3.
        set_data(0, 32'h100);
        set_data(3, 32'h103);
        req = 4'b1001;
        tick_auto(10);

        // One-cycle pulse with negative data.
        set_data(1, -32'sd5);
        req = 4'b0010;
        @(negedge clk);
        req = '0;
        check("pulse_s_in", 64'(s_in), 64'(32'hFFFF_FFFB));
        check("pulse_ack", 64'(ack), 64'(4'b0010));
        tick_auto(5);

        // Reset asserted in the middle of an issue cycle.
        set_data(0, 32'h55);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        rst = 1'b1;
        #1;
        check("midrst_sync", 64'(s_in_sync), 64'(0));
        check("midrst_ack", 64'(ack), 64'(0));
        check("midrst_s_in", 64'(s_in), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        tick_auto(8);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 800 == 799) begin
                req = '0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (ack[i] && $urandom_range(0, 7) != 0) begin
                        req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        set_data(i, DATA_W'($urandom));
                    end else if (req[i] && $urandom_range(0, 31) == 0) begin
                        req[i] = 1'b0;
                    end else if (req[i] && $urandom_range(0, 15) == 0) begin
                        set_data(i, DATA_W'($urandom));
                    end
                end
            end
        end

        req = '0;
        repeat (10) @(negedge clk);
        check("queue_drained", 64'(q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
